// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - character console writer: cursor tracking, line clear and full-screen clear
module text_console_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 45
) (
    input  logic       clk_125m,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [6:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       wr_en,
    output logic [6:0] wr_x,
    output logic [5:0] wr_y,
    output logic [6:0] wr_char,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LINE_CLR, CLR_ALL} state_t;

    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cx, w_cx_nxt;
    logic [5:0] r_cy, w_cy_nxt;
    logic [6:0] r_clr_x, w_clr_x_nxt;
    logic [5:0] r_clr_y, w_clr_y_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic [6:0] r_wr_x, w_wr_x_nxt;
    logic [5:0] r_wr_y, w_wr_y_nxt;
    logic [6:0] r_wr_char, w_wr_char_nxt;
    logic [5:0] w_next_row;
    logic       w_printable;

    assign w_next_row  = (r_cy == LAST_Y) ? 6'd0 : r_cy + 6'd1;
    assign w_printable = (char_data >= 7'h20) && (char_data <= 7'h7E);

    assign char_ready = (r_state == IDLE) && !clear_req;
    assign busy       = (r_state != IDLE);
    assign wr_en      = r_wr_en;
    assign wr_x       = r_wr_x;
    assign wr_y       = r_wr_y;
    assign wr_char    = r_wr_char;
    assign cursor_x   = r_cx;
    assign cursor_y   = r_cy;

    // State, cursor, clear counters and registered write port
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cx      <= 7'd0;
            r_cy      <= 6'd0;
            r_clr_x   <= 7'd0;
            r_clr_y   <= 6'd0;
            r_wr_en   <= 1'b0;
            r_wr_x    <= 7'd0;
            r_wr_y    <= 6'd0;
            r_wr_char <= 7'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cx      <= w_cx_nxt;
            r_cy      <= w_cy_nxt;
            r_clr_x   <= w_clr_x_nxt;
            r_clr_y   <= w_clr_y_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_x    <= w_wr_x_nxt;
            r_wr_y    <= w_wr_y_nxt;
            r_wr_char <= w_wr_char_nxt;
        end
    end

    // Next-state: character decode in IDLE, sweep counters in the clear states
    always_comb begin
        w_state_nxt   = r_state;
        w_cx_nxt      = r_cx;
        w_cy_nxt      = r_cy;
        w_clr_x_nxt   = r_clr_x;
        w_clr_y_nxt   = r_clr_y;
        w_wr_en_nxt   = 1'b0;
        w_wr_x_nxt    = r_wr_x;
        w_wr_y_nxt    = r_wr_y;
        w_wr_char_nxt = r_wr_char;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    // clear wins over a character offered in the same cycle
                    w_state_nxt = CLR_ALL;
                    w_clr_x_nxt = 7'd0;
                    w_clr_y_nxt = 6'd0;
                end else if (char_valid) begin
                    if (w_printable) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_x_nxt    = r_cx;
                        w_wr_y_nxt    = r_cy;
                        w_wr_char_nxt = char_data;
                        if (r_cx == LAST_X) begin
                            w_cx_nxt    = 7'd0;
                            w_cy_nxt    = w_next_row;
                            w_clr_x_nxt = 7'd0;
                            w_state_nxt = LINE_CLR;
                        end else begin
                            w_cx_nxt = r_cx + 7'd1;
                        end
                    end else if (char_data == 7'h0A) begin
                        w_cx_nxt    = 7'd0;
                        w_cy_nxt    = w_next_row;
                        w_clr_x_nxt = 7'd0;
                        w_state_nxt = LINE_CLR;
                    end else if (char_data == 7'h0D) begin
                        w_cx_nxt = 7'd0;
                    end else if (char_data == 7'h08 && r_cx != 7'd0) begin
                        w_cx_nxt      = r_cx - 7'd1;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_x_nxt    = r_cx - 7'd1;
                        w_wr_y_nxt    = r_cy;
                        w_wr_char_nxt = 7'd0;
                    end
                end
            end
            LINE_CLR: begin
                if (clear_req) begin
                    w_state_nxt = CLR_ALL;
                    w_clr_x_nxt = 7'd0;
                    w_clr_y_nxt = 6'd0;
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_x_nxt    = r_clr_x;
                    w_wr_y_nxt    = r_cy;
                    w_wr_char_nxt = 7'd0;
                    if (r_clr_x == LAST_X) begin
                        w_clr_x_nxt = 7'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_clr_x_nxt = r_clr_x + 7'd1;
                    end
                end
            end
            CLR_ALL: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_x_nxt    = r_clr_x;
                w_wr_y_nxt    = r_clr_y;
                w_wr_char_nxt = 7'd0;
                if (r_clr_x == LAST_X) begin
                    w_clr_x_nxt = 7'd0;
                    if (r_clr_y == LAST_Y) begin
                        w_clr_y_nxt = 6'd0;
                        w_cx_nxt    = 7'd0;
                        w_cy_nxt    = 6'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_clr_y_nxt = r_clr_y + 6'd1;
                    end
                end else begin
                    w_clr_x_nxt = r_clr_x + 7'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 Parameter COLS, default 80, sets the character columns per row.
REQ-002 Parameter ROWS, default 45, sets the character rows per screen.
REQ-003 Port clk_125m, input, 1 bit, is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port char_valid, input, 1 bit, indicates a character is offered.
REQ-006 Port char_data, input, 7 bits, carries the offered ASCII code.
REQ-007 Port char_ready, output, 1 bit, indicates the block accepts a character this cycle.
REQ-008 Port clear_req, input, 1 bit, is a single-cycle request to clear the whole screen.
REQ-009 Port wr_en, output, 1 bit, is the character-matrix cell write strobe.
REQ-010 Port wr_x, output, 7 bits, is the column of the cell being written.
REQ-011 Port wr_y, output, 6 bits, is the row of the cell being written.
REQ-012 Port wr_char, output, 7 bits, is the code written to the cell.
REQ-013 Port cursor_x, output, 7 bits, is the current cursor column.
REQ-014 Port cursor_y, output, 6 bits, is the current cursor row.
REQ-015 Port busy, output, 1 bit, is high whenever the state is not IDLE.

Function
REQ-016 A transfer SHALL occur on a rising edge where char_valid and char_ready are both high.
REQ-017 char_ready SHALL equal (state==IDLE) AND NOT clear_req.
REQ-018 States SHALL be IDLE, LINE_CLR and CLR_ALL.
REQ-019 All write-port outputs SHALL be registered; the wr_en pulse for an accepted character SHALL appear exactly one cycle after the transfer.
REQ-020 For a printable character (0x20..0x7E), the block SHALL write char_data at (cursor_x, cursor_y) and increment cursor_x.
REQ-021 If a printable character is written with cursor_x==COLS-1, the cursor SHALL move to (0, next row) and the state SHALL become LINE_CLR.
REQ-022 For LF (0x0A), the cursor SHALL move to (0, next row), no cell SHALL be written, and the state SHALL become LINE_CLR.
REQ-023 For CR (0x0D), cursor_x SHALL become 0 and no write SHALL occur.
REQ-024 For BS (0x08) with cursor_x>0, cursor_x SHALL decrement and 0x00 SHALL be written at the new position.
REQ-025 For BS (0x08) with cursor_x==0, there SHALL be no write and no cursor change.
REQ-026 Any other code SHALL be accepted and discarded with no write and no cursor change.
REQ-027 The next row SHALL be cursor_y+1, wrapping from ROWS-1 to 0.
REQ-028 LINE_CLR SHALL write 0x00 to columns 0..COLS-1 of the new cursor row, one per cycle with wr_en high for COLS consecutive cycles, then return to IDLE.
REQ-029 clear_req high in IDLE or LINE_CLR SHALL abort any activity, including a transfer that would otherwise occur that cycle, and enter CLR_ALL on the next edge.
REQ-030 CLR_ALL SHALL write 0x00 to all COLS*ROWS cells in row-major order from (0,0), one per cycle, with wr_en high for COLS*ROWS consecutive cycles.
REQ-031 When CLR_ALL completes, the cursor SHALL be (0,0) and the state SHALL return to IDLE.
REQ-032 clear_req SHALL be ignored while in CLR_ALL.
REQ-033 wr_en SHALL be low in every cycle not specified above.
REQ-034 wr_x SHALL never exceed COLS-1, and wr_y SHALL never exceed ROWS-1.

Reset
REQ-035 While rst_n is low, state SHALL be IDLE; cursor_x, cursor_y, wr_x, wr_y, wr_char and wr_en SHALL be 0; char_ready SHALL be 1; busy SHALL be 0.
REQ-036 Reset asserted mid-LINE_CLR or mid-CLR_ALL SHALL abort immediately, with no further wr_en after deassertion until a new transfer or clear_req.
REQ-037 No automatic screen clear SHALL follow reset.

Verification
REQ-038 Scenario: after reset, send 'A' (0x41) -> next cycle wr_en=1, wr_x=0, wr_y=0, wr_char=0x41; cursor becomes (1,0).
REQ-039 Scenario: send 80 'B' from (0,0) -> 80 writes in row 0; cursor becomes (0,1); busy for 80 cycles with row-1 zero writes; char_ready=0 throughout.
REQ-040 Scenario: cursor (5,44), send LF -> cursor becomes (0,0); LINE_CLR writes row 0, columns 0..79.
REQ-041 Scenario: cursor (3,2), send BS -> write 0x00 at (2,2); cursor becomes (2,2). A second BS at x=0 -> no write.
REQ-042 Scenario: clear_req on cycle 20 of a LINE_CLR -> CLR_ALL of 3600 writes ending at (79,44); cursor becomes (0,0); a char_valid held high in that same cycle is not accepted.
REQ-043 Scenario: rst_n pulsed low during CLR_ALL -> all outputs return to their reset values; no writes follow deassertion.
